// File: rtl/timer_multi.sv
// timer_multi: CHANNELS independent hh:mm:ss up/down timers
// sharing one second prescaler, loaded through one write port.
module timer_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 50_000_000,
    localparam int CH_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      cut_n,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic                      wr_up,
    input  logic [WIDTH-1:0]          wr_sec,
    input  logic [WIDTH-1:0]          wr_min,
    input  logic [WIDTH-1:0]          wr_hour,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       pause,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       alarm_ack,
    output logic [CHANNELS*WIDTH-1:0] sec,
    output logic [CHANNELS*WIDTH-1:0] min,
    output logic [CHANNELS*WIDTH-1:0] hour,
    output logic [CHANNELS-1:0]       alarm,
    output logic [CHANNELS-1:0]       busy_n,
    output logic                      wr_err
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADED,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] h;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] s;
    } hms_t;

    function automatic logic [WIDTH-1:0] clamp59(
        input logic [WIDTH-1:0] v
    );
        return (v > WIDTH'(59)) ? WIDTH'(59) : v;
    endfunction

    function automatic hms_t reload(
        input logic up,
        input hms_t t
    );
        hms_t r;
        if (up) r = '0;
        else    r = t;
        return r;
    endfunction

    function automatic logic at_term(
        input logic up,
        input hms_t d,
        input hms_t t
    );
        return up ? (d == t) : (d == '0);
    endfunction

    function automatic hms_t advance(
        input logic up,
        input hms_t d
    );
        hms_t r;
        r = d;
        if (up) begin
            if (d.s == WIDTH'(59)) begin
                r.s = '0;
                if (d.m == WIDTH'(59)) begin
                    r.m = '0;
                    r.h = d.h + 1'b1;
                end else begin
                    r.m = d.m + 1'b1;
                end
            end else begin
                r.s = d.s + 1'b1;
            end
        end else begin
            if (d.s == '0) begin
                r.s = WIDTH'(59);
                if (d.m == '0) begin
                    r.m = WIDTH'(59);
                    r.h = d.h - 1'b1;
                end else begin
                    r.m = d.m - 1'b1;
                end
            end else begin
                r.s = d.s - 1'b1;
            end
        end
        return r;
    endfunction

    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge cut_n) begin
        if (cut_n)     pre_q <= '0;
        else if (tick) pre_q <= '0;
        else           pre_q <= pre_q + 1'b1;
    end

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic                up_q    [CHANNELS];
    logic                up_d    [CHANNELS];
    hms_t                tgt_q   [CHANNELS];
    hms_t                tgt_d   [CHANNELS];
    hms_t                disp_q  [CHANNELS];
    hms_t                disp_d  [CHANNELS];
    logic [CHANNELS-1:0] alarm_q;
    logic [CHANNELS-1:0] alarm_d;
    logic [CHANNELS-1:0] busy_n_q;
    logic                wr_err_q;
    hms_t                wr_val;

    assign wr_val = '{
        h: wr_hour,
        m: clamp59(wr_min),
        s: clamp59(wr_sec)
    };

    // A write to a non-busy channel overrides its control inputs.
    always_comb begin
        alarm_d = alarm_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            up_d[i]    = up_q[i];
            tgt_d[i]   = tgt_q[i];
            disp_d[i]  = disp_q[i];
            if (wr_en && wr_ch == CH_W'(i) && busy_n_q[i]) begin
                state_d[i] = S_LOADED;
                up_d[i]    = wr_up;
                tgt_d[i]   = wr_val;
                disp_d[i]  = reload(wr_up, wr_val);
                alarm_d[i] = 1'b0;
            end else begin
                unique case (state_q[i])
                    S_LOADED: begin
                        if (!stop[i] && start[i]) begin
                            if (at_term(up_q[i], disp_q[i],
                                        tgt_q[i])) begin
                                state_d[i] = S_DONE;
                                alarm_d[i] = 1'b1;
                            end else begin
                                state_d[i] = S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (stop[i]) begin
                            state_d[i] = S_LOADED;
                            disp_d[i]  = reload(up_q[i], tgt_q[i]);
                        end else if (pause[i] && !start[i]) begin
                            state_d[i] = S_PAUSE;
                        end else if (tick) begin
                            disp_d[i] = advance(up_q[i], disp_q[i]);
                            if (at_term(up_q[i], disp_d[i],
                                        tgt_q[i])) begin
                                state_d[i] = S_DONE;
                                alarm_d[i] = 1'b1;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (stop[i]) begin
                            state_d[i] = S_LOADED;
                            disp_d[i]  = reload(up_q[i], tgt_q[i]);
                        end else if (start[i]) begin
                            state_d[i] = S_RUN;
                        end
                    end
                    S_DONE: begin
                        if (start[i]) begin
                            disp_d[i]  = reload(up_q[i], tgt_q[i]);
                            alarm_d[i] = 1'b0;
                            state_d[i] = S_RUN;
                            if (at_term(up_q[i], disp_d[i],
                                        tgt_q[i])) begin
                                state_d[i] = S_DONE;
                                alarm_d[i] = 1'b1;
                            end
                        end else if (alarm_ack[i]) begin
                            state_d[i] = S_LOADED;
                            disp_d[i]  = reload(up_q[i], tgt_q[i]);
                            alarm_d[i] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge cut_n) begin
        if (cut_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= S_IDLE;
                up_q[i]    <= 1'b0;
                tgt_q[i]   <= '0;
                disp_q[i]  <= '0;
            end
            alarm_q  <= '0;
            busy_n_q <= '1;
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                up_q[i]     <= up_d[i];
                tgt_q[i]    <= tgt_d[i];
                disp_q[i]   <= disp_d[i];
                busy_n_q[i] <= !(state_d[i] == S_RUN ||
                                 state_d[i] == S_PAUSE);
            end
            alarm_q  <= alarm_d;
            wr_err_q <= wr_en && !busy_n_q[wr_ch];
        end
    end

    always_comb begin
        sec  = '0;
        min  = '0;
        hour = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sec[i*WIDTH +: WIDTH]  = disp_q[i].s;
            min[i*WIDTH +: WIDTH]  = disp_q[i].m;
            hour[i*WIDTH +: WIDTH] = disp_q[i].h;
        end
    end

    assign alarm  = alarm_q;
    assign busy_n = busy_n_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: directed vector table plus hand-written
// multi-cycle sequences for timer_multi (TICK_DIV=4).
module tb_timer_multi;

    logic        clk = 1'b0;
    logic        cut_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic        wr_up = 1'b0;
    logic [15:0] wr_sec = '0;
    logic [15:0] wr_min = '0;
    logic [15:0] wr_hour = '0;
    logic [3:0]  start = '0;
    logic [3:0]  pause = '0;
    logic [3:0]  stop = '0;
    logic [3:0]  alarm_ack = '0;
    logic [63:0] sec;
    logic [63:0] min;
    logic [63:0] hour;
    logic [3:0]  alarm;
    logic [3:0]  busy_n;
    logic        wr_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    timer_multi #(
        .CHANNELS(4),
        .WIDTH(16),
        .TICK_DIV(4)
    ) dut (
        .clk(clk),
        .cut_n(cut_n),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_up(wr_up),
        .wr_sec(wr_sec),
        .wr_min(wr_min),
        .wr_hour(wr_hour),
        .start(start),
        .pause(pause),
        .stop(stop),
        .alarm_ack(alarm_ack),
        .sec(sec),
        .min(min),
        .hour(hour),
        .alarm(alarm),
        .busy_n(busy_n),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    // Edges since reset release; every 4th edge carries a tick.
    always @(posedge clk or posedge cut_n) begin
        if (cut_n) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic        up;
        logic [15:0] s, m, h;
        logic [3:0]  st, pa, sp, ak;
        int          cc;
        logic [15:0] es, em, eh;
        logic [3:0]  ea, eb;
        logic        ee;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] disp(input int ch);
        return {hour[ch*16 +: 16], min[ch*16 +: 16],
                sec[ch*16 +: 16]};
    endfunction

    task automatic step(input logic we, input logic [1:0] ch,
                        input logic up, input logic [15:0] s,
                        input logic [15:0] m, input logic [15:0] h,
                        input logic [3:0] st, input logic [3:0] pa,
                        input logic [3:0] sp, input logic [3:0] ak);
        wr_en = we;  wr_ch = ch;  wr_up = up;
        wr_sec = s;  wr_min = m;  wr_hour = h;
        start = st;  pause = pa;  stop = sp;  alarm_ack = ak;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0; start = '0; pause = '0;
        stop = '0;    alarm_ack = '0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic up,
                      input logic [15:0] s, input logic [15:0] m,
                      input logic [15:0] h);
        step(1'b1, ch, up, s, m, h, 4'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic ctl(input logic [3:0] st, input logic [3:0] pa,
                       input logic [3:0] sp, input logic [3:0] ak);
        step(1'b0, 2'd0, 1'b0, 16'd0, 16'd0, 16'd0, st, pa, sp, ak);
    endtask

    task automatic tick_wait();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (cyc % 4 != 0 && n < 8);
        if (cyc % 4 != 0) begin
            tests++;
            fails++;
            $display("FAIL tick_wait: no tick in %0d edges", n);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_sec"}, sec, 64'd0);
        chk({name, "_min"}, min, 64'd0);
        chk({name, "_hour"}, hour, 64'd0);
        chk({name, "_alarm"}, {60'd0, alarm}, 64'd0);
        chk({name, "_busy"}, {60'd0, busy_n}, 64'hf);
        chk({name, "_wrerr"}, {63'd0, wr_err}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1);
    end

    initial begin
        int rem;
        tbl[0]  = '{1, 3, 0, 75, 80, 300, 0, 0, 0, 0,
                    3, 59, 59, 300, 4'h0, 4'hf, 0};
        tbl[1]  = '{1, 2, 1, 5, 0, 0, 0, 0, 0, 0,
                    2, 0, 0, 0, 4'h0, 4'hf, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 0, 0, 0, 4'h0, 4'hf, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 4'h2, 0, 0, 0,
                    1, 0, 0, 0, 4'h2, 4'hf, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h2,
                    1, 0, 0, 0, 4'h0, 4'hf, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 4'h8, 4'h8, 0, 0,
                    3, 59, 59, 300, 4'h0, 4'h7, 0};
        tbl[6]  = '{1, 3, 0, 1, 1, 1, 0, 0, 0, 0,
                    3, 59, 59, 300, 4'h0, 4'h7, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    3, 58, 59, 300, 4'h0, 4'h7, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 4'h8, 0,
                    3, 59, 59, 300, 4'h0, 4'hf, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 4'h8, 4'h1, 0,
                    3, 59, 59, 300, 4'h0, 4'hf, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 4'h1, 0, 0, 0,
                    0, 0, 0, 0, 4'h0, 4'hf, 0};
        tbl[11] = '{1, 0, 0, 2, 3, 4, 4'h1, 0, 0, 0,
                    0, 2, 3, 4, 4'h0, 4'hf, 0};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        cut_n = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].we, tbl[i].ch, tbl[i].up, tbl[i].s,
                 tbl[i].m, tbl[i].h, tbl[i].st, tbl[i].pa,
                 tbl[i].sp, tbl[i].ak);
            chk($sformatf("v%0d_disp", i), {16'd0, disp(tbl[i].cc)},
                {16'd0, tbl[i].eh, tbl[i].em, tbl[i].es});
            chk($sformatf("v%0d_alarm", i), {60'd0, alarm},
                {60'd0, tbl[i].ea});
            chk($sformatf("v%0d_busy", i), {60'd0, busy_n},
                {60'd0, tbl[i].eb});
            chk($sformatf("v%0d_wrerr", i), {63'd0, wr_err},
                {63'd0, tbl[i].ee});
        end

        // ch0 counts down 0:1:2 to 0:0:0
        wr(2'd0, 1'b0, 16'd2, 16'd1, 16'd0);
        ctl(4'h1, 4'h0, 4'h0, 4'h0);
        chk("a_busy", {63'd0, busy_n[0]}, 64'd0);
        for (int k = 1; k <= 62; k++) begin
            tick_wait();
            rem = 62 - k;
            chk($sformatf("a_disp%0d", k), {16'd0, disp(0)},
                {32'd0, 16'(rem / 60), 16'(rem % 60)});
            chk($sformatf("a_alarm%0d", k), {63'd0, alarm[0]},
                {63'd0, k == 62});
            chk($sformatf("a_busy%0d", k), {63'd0, busy_n[0]},
                {63'd0, k == 62});
        end
        tick_wait();
        chk("a_hold", {16'd0, disp(0)}, 64'd0);
        chk("a_ch3", {16'd0, disp(3)}, {16'd0, 16'd300, 16'd59, 16'd59});
        chk("a_ch2", {16'd0, disp(2)}, 64'd0);
        chk("a_others", {60'd0, alarm}, 64'h1);

        // ch1 counts up to 0:1:0
        wr(2'd1, 1'b1, 16'd0, 16'd1, 16'd0);
        ctl(4'h2, 4'h0, 4'h0, 4'h0);
        for (int k = 1; k <= 60; k++) begin
            tick_wait();
            chk($sformatf("b_disp%0d", k), {16'd0, disp(1)},
                {32'd0, 16'(k / 60), 16'(k % 60)});
            chk($sformatf("b_alarm%0d", k), {63'd0, alarm[1]},
                {63'd0, k == 60});
        end
        ctl(4'h0, 4'h0, 4'h0, 4'h2);
        chk("b_ack_alarm", {63'd0, alarm[1]}, 64'd0);
        chk("b_ack_disp", {16'd0, disp(1)}, 64'd0);
        chk("b_ack_busy", {63'd0, busy_n[1]}, 64'd1);

        // ch2 pause / resume / stop
        wr(2'd2, 1'b0, 16'd30, 16'd0, 16'd0);
        ctl(4'h4, 4'h0, 4'h0, 4'h0);
        repeat (3) tick_wait();
        chk("c_run", {16'd0, disp(2)}, 64'd27);
        ctl(4'h0, 4'h4, 4'h0, 4'h0);
        chk("c_pause_busy", {63'd0, busy_n[2]}, 64'd0);
        for (int k = 0; k < 10; k++) begin
            tick_wait();
            chk($sformatf("c_frozen%0d", k), {16'd0, disp(2)}, 64'd27);
        end
        ctl(4'h4, 4'h0, 4'h0, 4'h0);
        tick_wait();
        chk("c_resume1", {16'd0, disp(2)}, 64'd26);
        tick_wait();
        chk("c_resume2", {16'd0, disp(2)}, 64'd25);
        ctl(4'h0, 4'h0, 4'h4, 4'h0);
        chk("c_stop_disp", {16'd0, disp(2)}, 64'd30);
        chk("c_stop_busy", {63'd0, busy_n[2]}, 64'd1);

        // stop+start+pause together on running ch1
        ctl(4'h2, 4'h0, 4'h0, 4'h0);
        chk("d_busy", {63'd0, busy_n[1]}, 64'd0);
        tick_wait();
        chk("d_run", {16'd0, disp(1)}, 64'd1);
        ctl(4'h2, 4'h2, 4'h2, 4'h0);
        chk("d_stop_disp", {16'd0, disp(1)}, 64'd0);
        chk("d_stop_busy", {63'd0, busy_n[1]}, 64'd1);
        tick_wait();
        chk("d_loaded", {16'd0, disp(1)}, 64'd0);
        wr(2'd1, 1'b0, 16'd0, 16'd0, 16'd0);
        ctl(4'h2, 4'h0, 4'h0, 4'h0);
        chk("d_done_alarm", {63'd0, alarm[1]}, 64'd1);
        chk("d_done_busy", {63'd0, busy_n[1]}, 64'd1);

        // async reset mid-count
        ctl(4'hd, 4'h0, 4'h0, 4'h0);
        chk("e_busy", {60'd0, busy_n}, 64'h2);
        repeat (2) tick_wait();
        chk("e_ch0", {16'd0, disp(0)}, {32'd0, 16'd1, 16'd0});
        cut_n = 1'b1;
        #1;
        chk_zero("e_async");
        @(posedge clk);
        @(negedge clk);
        cut_n = 1'b0;
        repeat (2) tick_wait();
        chk_zero("e_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
